// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register bank: register 0 is a read-only ID, the others are byte-strobed R/W.
// Write and read channels run independently; every output is registered.
module axi_lite_regfile #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h0001_0000
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  input  logic [2:0]                     AWPROT,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [$clog2(DATA_WIDTH)-1:0]  WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic                           BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic                           RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_stb_o
);

  localparam int NumRegs   = int'(NUM_REGS);
  localparam int IdxW      = $clog2(NUM_REGS);
  localparam int Lanes     = int'(DATA_WIDTH / 8);
  localparam int StrbW     = $clog2(DATA_WIDTH);
  localparam int UsedLanes = (Lanes < StrbW) ? Lanes : StrbW;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IdxW + 2)) == '0;
  endfunction

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]      w_strb_q, w_strb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                  commit, wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]      wr_strb;
  logic [IdxW-1:0]       wr_idx, rd_idx;

  // A channel handshaking this edge counts as held, so AW+W together commit at once.
  always_comb begin
    aw_hs   = AWVALID & awready_q;
    w_hs    = WVALID & wready_q;
    ar_hs   = ARVALID & arready_q;
    b_hs    = bvalid_q & BREADY;
    r_hs    = rvalid_q & RREADY;
    wr_addr = aw_held_q ? aw_addr_q : AWADDR;
    wr_data = w_held_q ? w_data_q : WDATA;
    wr_strb = w_held_q ? w_strb_q : WSTRB;
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    wr_idx  = wr_addr[IdxW+1:2];
    wr_ok   = addr_in_range(wr_addr) && (wr_idx != '0);
    rd_idx  = ARADDR[IdxW+1:2];
    rd_ok   = addr_in_range(ARADDR);
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_stb_d  = '0;
    regs_d    = regs_q;
    regs_d[0] = ID_VALUE;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = ~wr_ok;
      if (wr_ok) begin
        wr_stb_d[wr_idx] = 1'b1;
        for (int b = 0; b < UsedLanes; b++) begin
          if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    // Readies stay low while a channel is latched or a response is outstanding.
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Reads sample regs_q, so a same-edge write to the same register is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? regs_q[rd_idx] : '0;
      rresp_d  = ~rd_ok;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 1'b0;
      rdata_q   <= '0;
      wr_stb_q  <= '0;
      regs_q[0] <= ID_VALUE;
      for (int i = 1; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wr_stb_q  <= wr_stb_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NumRegs; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign wr_stb_o = wr_stb_q;

  logic unused_bits;
  assign unused_bits = ^{AWPROT, wr_addr[1:0], ARADDR[1:0], wr_strb};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the register bank.
module tb_axi_lite_regfile;

  localparam logic [31:0] Id = 32'h0001_0000;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [31:0]  AWADDR = '0;
  logic         AWVALID = 1'b0;
  logic [2:0]   AWPROT = '0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [4:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic         BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [31:0]  ARADDR = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic         RRESP;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [255:0] regs_o;
  logic [7:0]   wr_stb_o;

  axi_lite_regfile dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWPROT   (AWPROT),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .ARADDR   (ARADDR),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .regs_o   (regs_o),
    .wr_stb_o (wr_stb_o)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_regs [8];
  logic        m_started, m_aw_held, m_w_held, m_b_pend, m_b_resp, m_r_pend, m_r_resp;
  logic [31:0] m_aw_addr, m_w_data, m_r_data;
  logic [4:0]  m_w_strb;
  logic [7:0]  m_stb;

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'd32;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [4:0] strb);
    logic [31:0] mask = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic exp_awready();
    return m_started && !m_aw_held && !m_b_pend;
  endfunction
  function automatic logic exp_wready();
    return m_started && !m_w_held && !m_b_pend;
  endfunction
  function automatic logic exp_arready();
    return m_started && !m_r_pend;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_started = 0; m_aw_held = 0; m_w_held = 0; m_b_pend = 0; m_b_resp = 0;
    m_r_pend = 0; m_r_resp = 0; m_aw_addr = '0; m_w_data = '0; m_r_data = '0;
    m_w_strb = '0; m_stb = '0;
  endtask

  task automatic model_step();
    logic aw_hs, w_hs, ar_hs;
    logic [2:0] idx;
    aw_hs = AWVALID && exp_awready();
    w_hs  = WVALID && exp_wready();
    ar_hs = ARVALID && exp_arready();
    m_stb = '0;
    if (ar_hs) begin
      idx = ARADDR[4:2];
      m_r_pend = 1;
      if (!in_range(ARADDR)) begin
        m_r_data = '0; m_r_resp = 1;
      end else begin
        m_r_data = (idx == 0) ? Id : m_regs[idx]; m_r_resp = 0;
      end
    end else if (m_r_pend && RREADY) begin
      m_r_pend = 0;
    end
    if (aw_hs) begin m_aw_held = 1; m_aw_addr = AWADDR; end
    if (w_hs) begin m_w_held = 1; m_w_data = WDATA; m_w_strb = WSTRB; end
    if (m_aw_held && m_w_held) begin
      idx = m_aw_addr[4:2];
      if (in_range(m_aw_addr) && idx != 0) begin
        m_regs[idx] = merge(m_regs[idx], m_w_data, m_w_strb);
        m_stb = 8'(1) << idx;
        m_b_resp = 0;
      end else begin
        m_b_resp = 1;
      end
      m_b_pend = 1; m_aw_held = 0; m_w_held = 0;
    end else if (m_b_pend && BREADY) begin
      m_b_pend = 0;
    end
    m_started = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge ACLK or negedge ARESETn);
      if (!ARESETn) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge ACLK);
      chk("awready", 32'(AWREADY), 32'(exp_awready()));
      chk("wready", 32'(WREADY), 32'(exp_wready()));
      chk("arready", 32'(ARREADY), 32'(exp_arready()));
      chk("bvalid", 32'(BVALID), 32'(m_b_pend));
      chk("rvalid", 32'(RVALID), 32'(m_r_pend));
      chk("wr_stb", 32'(wr_stb_o), 32'(m_stb));
      if (m_b_pend) chk("bresp", 32'(BRESP), 32'(m_b_resp));
      if (m_r_pend) begin
        chk("rdata", RDATA, m_r_data);
        chk("rresp", 32'(RRESP), 32'(m_r_resp));
      end
      for (int i = 0; i < 8; i++)
        chk($sformatf("reg%0d", i), regs_o[i*32 +: 32], (i == 0) ? Id : m_regs[i]);
    end
  end

  // ---------------- drivers (entered on a falling edge) ----------------
  task automatic drive_aw(input logic [31:0] a, input int unsigned dly);
    int n = 0;
    repeat (dly) @(negedge ACLK);
    AWADDR = a; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("aw_accept", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [4:0] s, input int unsigned dly);
    int n = 0;
    repeat (dly) @(negedge ACLK);
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("w_accept", 32'(WREADY), 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [4:0] s,
                          input int unsigned adly, input int unsigned wdly,
                          input int unsigned bdly, output logic resp);
    int n = 0;
    fork
      drive_aw(a, adly);
      drive_w(d, s, wdly);
    join
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("b_arrive", 32'(BVALID), 32'd1);
    repeat (bdly) @(negedge ACLK);
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int unsigned rdly,
                         output logic [31:0] data, output logic resp);
    int n = 0;
    ARADDR = a; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("ar_accept", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("r_arrive", 32'(RVALID), 32'd1);
    repeat (rdly) @(negedge ACLK);
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a, wd;
    logic        r, br;
    int unsigned kind;

    repeat (3) @(negedge ACLK);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_bresp", 32'(BRESP), 32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Same-cycle AW/W, then read back.
    do_write(32'h04, 32'hDEAD_BEEF, 5'hF, 0, 0, 0, br);
    chk("t1_bresp", 32'(br), 32'd0);
    do_read(32'h04, 0, d, r);
    chk("t1_rdata", d, 32'hDEAD_BEEF);
    chk("t1_rresp", 32'(r), 32'd0);

    // W three cycles ahead of AW, sparse strobes.
    do_write(32'h08, 32'h1122_3344, 5'h5, 3, 0, 0, br);
    chk("t2_reg2", regs_o[64 +: 32], 32'h0022_0044);

    // Stalled B response with a second write queued behind it.
    fork
      do_write(32'h0C, 32'hCAFE_F00D, 5'hF, 0, 0, 4, br);
      begin
        repeat (2) @(negedge ACLK);
        do_write(32'h10, 32'h1234_5678, 5'hF, 0, 0, 0, r);
      end
    join
    chk("t3_reg3", regs_o[96 +: 32], 32'hCAFE_F00D);
    chk("t3_reg4", regs_o[128 +: 32], 32'h1234_5678);

    // ID register and out-of-range accesses.
    do_write(32'h00, 32'hFFFF_FFFF, 5'hF, 0, 0, 0, br);
    chk("t4_bresp_id", 32'(br), 32'd1);
    do_write(32'h20, 32'hFFFF_FFFF, 5'hF, 1, 0, 0, br);
    chk("t4_bresp_oor", 32'(br), 32'd1);
    do_read(32'h00, 0, d, r);
    chk("t4_id", d, 32'h0001_0000);
    chk("t4_id_resp", 32'(r), 32'd0);
    do_read(32'h20, 0, d, r);
    chk("t4_oor_data", d, 32'd0);
    chk("t4_oor_resp", 32'(r), 32'd1);

    // Read shares its AR edge with a write commit to the same register.
    fork
      do_read(32'h0C, 5, d, r);
      do_write(32'h0C, 32'h0BAD_C0DE, 5'hF, 0, 0, 0, br);
    join
    chk("t5_old", d, 32'hCAFE_F00D);
    do_read(32'h0C, 0, d, r);
    chk("t5_new", d, 32'h0BAD_C0DE);

    // Reset with a read response pending and AW latched.
    drive_aw(32'h04, 0);
    ARADDR = 32'h0C; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("t6_rvalid_pre", 32'(RVALID), 32'd1);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_awready", 32'(AWREADY), 32'd0);
    chk("t6_wready", 32'(WREADY), 32'd0);
    chk("t6_arready", 32'(ARREADY), 32'd0);
    chk("t6_rvalid", 32'(RVALID), 32'd0);
    chk("t6_rdata", RDATA, 32'd0);
    chk("t6_bvalid", 32'(BVALID), 32'd0);
    chk("t6_stb", 32'(wr_stb_o), 32'd0);
    for (int i = 1; i < 8; i++) chk($sformatf("t6_reg%0d", i), regs_o[i*32 +: 32], 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    for (int i = 0; i < 8; i++) begin
      do_read(32'(i * 4), 0, d, r);
      chk($sformatf("t6_rd%0d", i), d, (i == 0) ? 32'h0001_0000 : 32'd0);
    end

    // Random traffic; the per-cycle comparison does the checking.
    for (int it = 0; it < 200; it++) begin
      kind = $urandom_range(0, 2);
      a = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:5] == '0) a = a | 32'h20;
      end
      wd = $urandom;
      case (kind)
        0: do_write(a, wd, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), br);
        1: do_read(a, $urandom_range(0, 3), d, r);
        default: fork
          do_write(a, wd, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 3), br);
          do_read({27'd0, 3'($urandom_range(0, 7)), 2'b00}, $urandom_range(0, 4), d, r);
        join
      endcase
    end

    repeat (3) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
